// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester (CPU = 0, DMA = 1) arbiter for a single-port data memory.
//   One access is in flight at a time through a three-state FSM
//   (IDLE -> ACCESS -> DONE). Simultaneous requests are resolved round-robin
//   against the last granted requester.
//
// Optional build macro:
//   DMEM_ARB_CHECK_EN - when defined, misaligned or out-of-range addresses
//                       are rejected (no memory strobe, Err pulsed with Done).
//
// Parameters:
//   DMSize      - data memory size in bytes, used for the range check
//
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   Req0/Req1            - access requests (sampled only in IDLE)
//   Write0/Write1        - 1 = store word, 0 = load word
//   Addr0/Addr1          - byte addresses
//   WData0/WData1        - store data
//   Done0/Done1          - one-cycle completion pulse per requester
//   RData0/RData1        - last load result per requester
//   Err0/Err1            - rejected-access flag, valid with Done
//   Busy                 - FSM not in IDLE
//   MemoryRead/Write     - memory strobes (ACCESS state only)
//   Address, InputData   - memory address / write data (latched command)
//   OutputData           - combinational memory read data
module dmem_arbiter #(
  parameter int DMSize = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Write0,
  input  logic        Write1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Done0,
  output logic        Done1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic        Err0,
  output logic        Err1,
  output logic        Busy,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  output logic [31:0] Address,
  output logic [31:0] InputData,
  input  logic [31:0] OutputData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  // Winner selection: a sole requester wins outright; on a tie the requester
  // that was not served last time wins.
  logic        win;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  assign win       = (Req0 && Req1) ? ~last_grant_q : Req1;
  assign sel_write = win ? Write1 : Write0;
  assign sel_addr  = win ? Addr1  : Addr0;
  assign sel_wdata = win ? WData1 : WData0;

`ifdef DMEM_ARB_CHECK_EN
  localparam logic [31:0] AddrMax = 32'(DMSize - 4);

  logic err_q, err_d;
  logic sel_bad;

  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > AddrMax);
`else
  logic unused_cfg;
  assign unused_cfg = (DMSize > 0);
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef DMEM_ARB_CHECK_EN
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          grant_d     = win;
          cmd_write_d = sel_write;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          state_d     = ACCESS;
`ifdef DMEM_ARB_CHECK_EN
          err_d = 1'b0;
          // Rejected accesses skip ACCESS so no strobe is ever raised.
          if (sel_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ACCESS: begin
        state_d = DONE;
        // Load data is captured from memory on the ACCESS -> DONE edge.
        if (!cmd_write_q) begin
          if (grant_q) rdata1_d = OutputData;
          else         rdata0_d = OutputData;
        end
      end
      DONE: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      grant_q      <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= 32'h0;
      cmd_wdata_q  <= 32'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
`ifdef DMEM_ARB_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef DMEM_ARB_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  // Strobes are decoded from the current state, so a reset arriving during
  // ACCESS still lets memory commit the store at that same edge.
  assign Busy        = (state_q != IDLE);
  assign MemoryWrite = (state_q == ACCESS) &&  cmd_write_q;
  assign MemoryRead  = (state_q == ACCESS) && !cmd_write_q;
  assign Address     = cmd_addr_q;
  assign InputData   = cmd_wdata_q;
  assign Done0       = (state_q == DONE) && !grant_q;
  assign Done1       = (state_q == DONE) &&  grant_q;
  assign RData0      = rdata0_q;
  assign RData1      = rdata1_q;

`ifdef DMEM_ARB_CHECK_EN
  assign Err0 = Done0 && err_q;
  assign Err1 = Done1 && err_q;
`else
  assign Err0 = 1'b0;
  assign Err1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed testbench for dmem_arbiter with a small word memory model.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled at the same point, away from the active edge.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        Req0, Req1, Write0, Write1;
  logic [31:0] Addr0, Addr1, WData0, WData1;
  logic        Done0, Done1, Err0, Err1, Busy, MemoryRead, MemoryWrite;
  logic [31:0] RData0, RData1, Address, InputData, OutputData;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] mem [0:255];

  localparam logic [31:0] VAL_A = 32'hAAAA0040;
  localparam logic [31:0] VAL_B = 32'hBBBB0044;

  dmem_arbiter #(.DMSize(1024)) dut (
    .clock(clock), .reset(reset),
    .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Done0(Done0), .Done1(Done1), .RData0(RData0), .RData1(RData1),
    .Err0(Err0), .Err1(Err1), .Busy(Busy),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .Address(Address), .InputData(InputData), .OutputData(OutputData)
  );

  always #5 clock = ~clock;

  // Memory model: combinational read, store committed at the rising edge.
  assign OutputData = mem[Address[9:2]];
  always @(posedge clock) if (MemoryWrite) mem[Address[9:2]] <= InputData;

  always @(negedge clock) begin
    if (MemoryWrite) wr_cnt++;
    if (MemoryRead)  rd_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if ({Done0, Done1, Err0, Err1} !== 4'b0) begin bad++; $display("FAIL reset_done_err got=%b want=0000", {Done0, Done1, Err0, Err1}); end
    total++; if ({MemoryRead, MemoryWrite} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {MemoryRead, MemoryWrite}); end
    total++; if (Address !== 32'h0 || InputData !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h/%h want=0/0", Address, InputData); end
    total++; if (RData0 !== 32'h0 || RData1 !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", RData0, RData1); end
    $display("txn reset done");
  endtask

  task automatic test_store_load;
    int w0;
    w0 = wr_cnt;
    // Store 0xDEADBEEF to 0x10 from requester 0.
    Req0 = 1'b1; Write0 = 1'b1; Addr0 = 32'h10; WData0 = 32'hDEADBEEF;
    total++; if (Done0 !== 1'b0) begin bad++; $display("FAIL st_c1_done0 got=%b want=0", Done0); end
    tick();
    total++; if (MemoryWrite !== 1'b1 || MemoryRead !== 1'b0) begin bad++; $display("FAIL st_access_strobe got=%b%b want=01", MemoryRead, MemoryWrite); end
    total++; if (Address !== 32'h10 || InputData !== 32'hDEADBEEF) begin bad++; $display("FAIL st_access_bus got=%h/%h want=10/deadbeef", Address, InputData); end
    total++; if (Done0 !== 1'b0) begin bad++; $display("FAIL st_c2_done0 got=%b want=0", Done0); end
    tick();
    total++; if (Done0 !== 1'b1 || Done1 !== 1'b0 || Busy !== 1'b1) begin bad++; $display("FAIL st_c3_done got=%b%b%b want=101", Done0, Done1, Busy); end
    total++; if (MemoryWrite !== 1'b0) begin bad++; $display("FAIL st_done_wr got=%b want=0", MemoryWrite); end
    Req0 = 1'b0;
    tick();
    total++; if (Done0 !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL st_idle got=%b%b want=00", Done0, Busy); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL st_wr_cycles got=%0d want=1", wr_cnt - w0); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL st_mem got=%h want=deadbeef", mem[4]); end
    $display("txn req0 store addr=00000010 data=deadbeef");
    // Load it back.
    Req0 = 1'b1; Write0 = 1'b0; Addr0 = 32'h10;
    tick();
    total++; if (MemoryRead !== 1'b1 || MemoryWrite !== 1'b0) begin bad++; $display("FAIL ld_access_strobe got=%b%b want=10", MemoryRead, MemoryWrite); end
    tick();
    total++; if (Done0 !== 1'b1) begin bad++; $display("FAIL ld_c3_done0 got=%b want=1", Done0); end
    total++; if (RData0 !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata0 got=%h want=deadbeef", RData0); end
    Req0 = 1'b0;
    tick();
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL ld_no_write got=%0d want=1", wr_cnt - w0); end
    $display("txn req0 load addr=00000010 data=%h", RData0);
  endtask

  task automatic test_round_robin;
    logic exp0, exp1;
    reset = 1'b1; tick(); reset = 1'b0;
    mem[16] = VAL_A;
    mem[17] = VAL_B;
    Req0 = 1'b1; Write0 = 1'b0; Addr0 = 32'h40;
    Req1 = 1'b1; Write1 = 1'b0; Addr1 = 32'h44;
    // Both held: grants 0,1,0,1 -> Done0 at cycles 3,9; Done1 at 6,12.
    for (int c = 1; c <= 12; c++) begin
      exp0 = (c % 6 == 3);
      exp1 = (c % 6 == 0);
      total++; if (Done0 !== exp0 || Done1 !== exp1) begin bad++; $display("FAIL rr_cycle%0d got=%b%b want=%b%b", c, Done0, Done1, exp0, exp1); end
      if (c % 3 == 0) $display("txn rr cycle=%0d done0=%b done1=%b", c, Done0, Done1);
      if (c < 12) tick();
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    total++; if (RData0 !== VAL_A || RData1 !== VAL_B) begin bad++; $display("FAIL rr_rdata got=%h/%h want=%h/%h", RData0, RData1, VAL_A, VAL_B); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", Busy); end
  endtask

  task automatic test_ignore_in_access;
    Req1 = 1'b1; Write1 = 1'b1; Addr1 = 32'h20; WData1 = 32'h55AA55AA;
    tick();
    // Req0 rises while requester 1 is in ACCESS.
    Req0 = 1'b1; Write0 = 1'b0; Addr0 = 32'h20;
    total++; if (MemoryWrite !== 1'b1 || Address !== 32'h20) begin bad++; $display("FAIL ig_access got=%b/%h want=1/20", MemoryWrite, Address); end
    tick();
    total++; if (Done1 !== 1'b1 || Done0 !== 1'b0) begin bad++; $display("FAIL ig_done1 got=%b%b want=01", Done0, Done1); end
    Req1 = 1'b0;
    tick();
    total++; if (Busy !== 1'b0 || Done0 !== 1'b0) begin bad++; $display("FAIL ig_idle got=%b%b want=00", Busy, Done0); end
    tick();
    total++; if (MemoryRead !== 1'b1 || Address !== 32'h20) begin bad++; $display("FAIL ig_req0_access got=%b/%h want=1/20", MemoryRead, Address); end
    tick();
    total++; if (Done0 !== 1'b1) begin bad++; $display("FAIL ig_done0 got=%b want=1", Done0); end
    total++; if (RData1 !== VAL_B) begin bad++; $display("FAIL ig_rdata1 got=%h want=%h", RData1, VAL_B); end
    total++; if (RData0 !== 32'h55AA55AA) begin bad++; $display("FAIL ig_rdata0 got=%h want=55aa55aa", RData0); end
    Req0 = 1'b0;
    tick();
    $display("txn req1 store addr=00000020, then req0 load data=%h", RData0);
  endtask

  task automatic test_bad_addr;
    int r0;
    r0 = rd_cnt;
    Req0 = 1'b1; Write0 = 1'b0; Addr0 = 32'h13;
    tick();
`ifdef DMEM_ARB_CHECK_EN
    total++; if (Done0 !== 1'b1 || Err0 !== 1'b1) begin bad++; $display("FAIL bad0_done_err got=%b%b want=11", Done0, Err0); end
    Req0 = 1'b0;
    tick();
    total++; if (RData0 !== 32'h55AA55AA) begin bad++; $display("FAIL bad0_rdata got=%h want=55aa55aa", RData0); end
`else
    total++; if (MemoryRead !== 1'b1) begin bad++; $display("FAIL bad0_strobe got=%b want=1", MemoryRead); end
    tick();
    total++; if (Done0 !== 1'b1 || Err0 !== 1'b0) begin bad++; $display("FAIL bad0_done_err got=%b%b want=10", Done0, Err0); end
    Req0 = 1'b0;
    tick();
    total++; if (RData0 !== 32'hDEADBEEF) begin bad++; $display("FAIL bad0_rdata got=%h want=deadbeef", RData0); end
`endif
    $display("txn req0 load addr=00000013 rdata=%h", RData0);
    Req1 = 1'b1; Write1 = 1'b0; Addr1 = 32'h400;
    tick();
`ifdef DMEM_ARB_CHECK_EN
    total++; if (Done1 !== 1'b1 || Err1 !== 1'b1) begin bad++; $display("FAIL bad1_done_err got=%b%b want=11", Done1, Err1); end
    Req1 = 1'b0;
    tick();
    total++; if (RData1 !== VAL_B) begin bad++; $display("FAIL bad1_rdata got=%h want=%h", RData1, VAL_B); end
    total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL bad_no_strobe got=%0d want=0", rd_cnt - r0); end
`else
    tick();
    total++; if (Done1 !== 1'b1 || Err1 !== 1'b0) begin bad++; $display("FAIL bad1_done_err got=%b%b want=10", Done1, Err1); end
    Req1 = 1'b0;
    tick();
    total++; if (RData1 !== 32'hC0DE0000) begin bad++; $display("FAIL bad1_rdata got=%h want=c0de0000", RData1); end
    total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL bad_strobes got=%0d want=2", rd_cnt - r0); end
`endif
    $display("txn req1 load addr=00000400 rdata=%h", RData1);
  endtask

  task automatic test_reset_in_access;
    Req0 = 1'b1; Write0 = 1'b1; Addr0 = 32'h8; WData0 = 32'h12345678;
    tick();
    reset = 1'b1; Req0 = 1'b0;
    total++; if (MemoryWrite !== 1'b1) begin bad++; $display("FAIL rst_access_wr got=%b want=1", MemoryWrite); end
    tick();
    total++; if (mem[2] !== 32'h12345678) begin bad++; $display("FAIL rst_mem got=%h want=12345678", mem[2]); end
    total++; if ({Done0, Done1, Busy, MemoryRead, MemoryWrite} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {Done0, Done1, Busy, MemoryRead, MemoryWrite}); end
    total++; if (Address !== 32'h0 || InputData !== 32'h0 || RData0 !== 32'h0 || RData1 !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h want=0/0/0/0", Address, InputData, RData0, RData1); end
    reset = 1'b0;
    tick();
    total++; if (Done0 !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b%b want=00", Done0, Busy); end
    $display("txn req0 store addr=00000008 interrupted by reset, mem=%h", mem[2]);
  endtask

  initial begin
    reset = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0; Write0 = 1'b0; Write1 = 1'b0;
    Addr0 = 32'h0; Addr1 = 32'h0; WData0 = 32'h0; WData1 = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    test_reset();
    test_store_load();
    test_round_robin();
    test_ignore_in_access();
    test_bad_addr();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
